dpm_port_arbiter: RTL and testbench
===================================

Name: dpm_port_arbiter

Overview:
- Shares the two ports (A, B) of the 64K x 32 dual-port word memory between N independent requesters.
- Each cycle it grants up to two requests in round-robin order, first to port A and second to port B.
- It blocks same-word write hazards across the two ports.
- It returns a registered response (read data or write ack) one cycle after grant.
- It sits between the core/DMA/debug masters and the memory instance; it does not drive the memory reset.

Parameters:
- N, 4, number of requesters (2..8).
- ADDR_W, 16, word-address width; must match the memory's 16-bit address ports.
- PTR_W, $clog2(N), width of the round-robin pointer (localparam).

Ports:
- i_clk  in  1  clock.
- i_reset  in  1  synchronous, active-high reset.
- i_req_valid  in  N  request valid, one bit per requester.
- i_req_addr  in  N x ADDR_W  word address per requester.
- i_req_we  in  N  1 = write, 0 = read.
- i_req_wdata  in  N x 32  write data.
- i_req_bmask  in  N x 4  byte-lane enables for writes.
- o_req_ready  out  N  grant; transfer occurs when valid & ready.
- o_rsp_valid  out  N  one-cycle response strobe.
- o_rsp_rdata  out  N x 32  read data; 0 for write acks.
- o_mem_addr_a, o_mem_addr_b  out  16  memory addresses.
- o_mem_wdata_a, o_mem_wdata_b  out  32  write data.
- o_mem_bmask_a, o_mem_bmask_b  out  4  byte masks.
- o_mem_wren_a, o_mem_wren_b  out  1  write enables.
- i_mem_rdata_a, i_mem_rdata_b  in  32  combinational read data from memory.

Behaviour:
- Reset (i_reset=1 at posedge):
  - rr_ptr=0; o_rsp_valid=0; o_rsp_rdata all 0.
  - Internal response tags cleared; in-flight responses are dropped.
  - While i_reset is high: o_req_ready=0, o_mem_wren_a/b=0, mem address/data/mask outputs 0.
- Grant selection (combinational, every cycle):
  - Scan requesters from index rr_ptr upward, wrapping modulo N.
  - First valid requester -> port A (gA). Next valid requester -> port B (gB), subject to the hazard rule.
- Hazard rule: gB is suppressed (ready=0, remains pending) if addr[gB]==addr[gA] and either request is a write.
  - When gB is suppressed, the scan does NOT continue to further requesters that cycle.
  - Two reads to the same word are both granted.
- o_req_ready[i]=1 only for granted indices. Ready is allowed to depend combinationally on i_req_valid.
- Requester rules while valid & !ready: hold addr/we/wdata/bmask stable; do not drop valid.
- Memory drive:
  - Port X carries the granted request's fields.
  - wren_X = we of that request.
  - Idle port: addr 0, wren 0, bmask 0.
- Pointer update at posedge:
  - If any grant: rr_ptr = (last granted index + 1) mod N.
  - Otherwise rr_ptr holds.
- Response, latency exactly 1 cycle:
  - At the posedge ending the grant cycle, o_rsp_valid[g]=1 for each granted g, for one cycle.
  - o_rsp_rdata[g] = i_mem_rdata_X sampled that cycle for reads (pre-write contents); 0 for writes.
  - Non-granted lanes: rsp_valid=0, rdata holds its previous value.
- Throughput: a requester may hold valid continuously and is granted on consecutive cycles if it wins.
- Fairness: every continuously valid requester is granted within N cycles, including under hazard suppression.
- N=1 requester valid: uses port A only. Port B is never used without port A.

Decomposition:
- Package dpm_arb_pkg:
  - DPM_ADDR_W=16, DPM_DATA_W=32, DPM_BMASK_W=4.
  - typedef struct packed dpm_req_t {addr, we, wdata, bmask}.
  - typedef enum {PORT_A, PORT_B} dpm_port_e.
- One sub-module, dpm_rr_pick2:
  - Inputs: N-bit valid vector, rr_ptr.
  - Outputs: first/second index plus found flags.
  - Purely combinational.
- The hazard check, pointer register and response registers live in dpm_port_arbiter.

Test Plan:
- Reset: assert i_reset for 2 cycles with all valid=1 -> ready=0, wren_a/b=0, rsp_valid=0, rr_ptr=0; first cycle after release grants req0->A, req1->B.
- Round-robin: all 4 requesters valid with reads to distinct addresses -> grants (0,1),(2,3),(0,1); each rsp_valid fires the cycle after its grant.
- Write then read: req0 writes 0xDEADBEEF, bmask 4'b0101, addr 0x0010, word pre-filled 0x11223344; next cycle req1 reads 0x0010 -> rdata 0x11AD33EF.
- Hazard: rr_ptr=0, req0 writes 0x0020, req1 reads 0x0020 -> only req0 ready; req1 granted next cycle and returns the new data. Two reads to 0x0020 -> both granted.
- Starvation: req0 and req2 always valid with the same-address write, req1 idle -> grants alternate 0,2,0,2; neither waits more than N cycles.
- Reset mid-operation: grant req3 read, assert i_reset on the following edge -> no rsp_valid for req3; arbiter returns to rr_ptr=0.

Source files
------------

// File: rtl/dpm_port_arbiter_pkg.sv
// Shared types and widths for the dual-port memory arbiter slice.
// Request fields mirror the 64K x 32 word memory's port widths.
package dpm_arb_pkg;

   localparam int DPM_ADDR_W  = 16;
   localparam int DPM_DATA_W  = 32;
   localparam int DPM_BMASK_W = 4;

   typedef struct packed {
      logic [DPM_ADDR_W-1:0]  addr;
      logic                   we;
      logic [DPM_DATA_W-1:0]  wdata;
      logic [DPM_BMASK_W-1:0] bmask;
   } dpm_req_t;

   typedef enum logic {
      PORT_A = 1'b0,
      PORT_B = 1'b1
   } dpm_port_e;

   // Same-word access where at least one side writes must not share a cycle.
   function automatic logic dpm_is_hazard(input dpm_req_t a, input dpm_req_t b);
      return (a.addr == b.addr) && (a.we || b.we);
   endfunction

endpackage

// File: rtl/dpm_port_arbiter_if.sv
// Requester-side handshake bundle: N request lanes plus their response strobes.
interface dpm_port_arbiter_if #(
   parameter int N      = 4,
   parameter int ADDR_W = 16
) ();
   import dpm_arb_pkg::*;

   logic [N-1:0]                  req_valid;
   logic [N-1:0][ADDR_W-1:0]      req_addr;
   logic [N-1:0]                  req_we;
   logic [N-1:0][DPM_DATA_W-1:0]  req_wdata;
   logic [N-1:0][DPM_BMASK_W-1:0] req_bmask;
   logic [N-1:0]                  req_ready;
   logic [N-1:0]                  rsp_valid;
   logic [N-1:0][DPM_DATA_W-1:0]  rsp_rdata;

   modport master (
      output req_valid, req_addr, req_we, req_wdata, req_bmask,
      input  req_ready, rsp_valid, rsp_rdata
   );

   modport slave (
      input  req_valid, req_addr, req_we, req_wdata, req_bmask,
      output req_ready, rsp_valid, rsp_rdata
   );

endinterface

// File: rtl/dpm_port_arbiter_rr_pick2.sv
// Round-robin picker: finds the first two set bits of a valid vector,
// scanning upward from the pointer and wrapping modulo N.
module dpm_rr_pick2 #(
   parameter  int N     = 4,
   localparam int PTR_W = $clog2(N)
) (
   input  logic [N-1:0]     i_valid,
   input  logic [PTR_W-1:0] i_ptr,
   output logic [PTR_W-1:0] o_first_idx,
   output logic             o_first_found,
   output logic [PTR_W-1:0] o_second_idx,
   output logic             o_second_found
);

   int               pos;
   logic [PTR_W-1:0] cand;

   always_comb begin
      o_first_idx    = '0;
      o_first_found  = 1'b0;
      o_second_idx   = '0;
      o_second_found = 1'b0;
      pos            = 0;
      cand           = '0;
      for (int k = 0; k < N; k++) begin
         pos = int'(i_ptr) + k;
         if (pos >= N) pos = pos - N;
         cand = PTR_W'(pos);
         if (i_valid[cand]) begin
            if (!o_first_found) begin
               o_first_found = 1'b1;
               o_first_idx   = cand;
            end else if (!o_second_found) begin
               o_second_found = 1'b1;
               o_second_idx   = cand;
            end
         end
      end
   end

endmodule

// File: rtl/dpm_port_arbiter.sv
// Shares ports A/B of the dual-port word memory among N requesters with
// round-robin grants, same-word write hazard blocking and 1-cycle responses.
module dpm_port_arbiter
   import dpm_arb_pkg::*;
#(
   parameter  int N      = 4,
   parameter  int ADDR_W = DPM_ADDR_W,
   localparam int PTR_W  = $clog2(N)
) (
   input  logic                   i_clk,
   input  logic                   i_reset,
   dpm_port_arbiter_if.slave      req_if,
   output logic [ADDR_W-1:0]      o_mem_addr_a,
   output logic [ADDR_W-1:0]      o_mem_addr_b,
   output logic [DPM_DATA_W-1:0]  o_mem_wdata_a,
   output logic [DPM_DATA_W-1:0]  o_mem_wdata_b,
   output logic [DPM_BMASK_W-1:0] o_mem_bmask_a,
   output logic [DPM_BMASK_W-1:0] o_mem_bmask_b,
   output logic                   o_mem_wren_a,
   output logic                   o_mem_wren_b,
   input  logic [DPM_DATA_W-1:0]  i_mem_rdata_a,
   input  logic [DPM_DATA_W-1:0]  i_mem_rdata_b
);

   dpm_req_t                     req [N];
   logic [PTR_W-1:0]             rr_ptr;
   logic [PTR_W-1:0]             first_idx, second_idx, last_idx, next_ptr;
   logic                         first_found, second_found;
   logic                         hazard, grant_a, grant_b;
   logic [N-1:0]                 ready;
   dpm_port_e                    lane_port [N];
   logic [N-1:0]                 rsp_valid_q;
   logic [N-1:0][DPM_DATA_W-1:0] rsp_rdata_q;

   always_comb begin
      for (int i = 0; i < N; i++) begin
         req[i].addr  = DPM_ADDR_W'(req_if.req_addr[i]);
         req[i].we    = req_if.req_we[i];
         req[i].wdata = req_if.req_wdata[i];
         req[i].bmask = req_if.req_bmask[i];
      end
   end

   dpm_rr_pick2 #(.N(N)) u_pick (
      .i_valid        (req_if.req_valid),
      .i_ptr          (rr_ptr),
      .o_first_idx    (first_idx),
      .o_first_found  (first_found),
      .o_second_idx   (second_idx),
      .o_second_found (second_found)
   );

   // A suppressed port-B candidate ends the scan; it simply stays pending.
   always_comb begin
      hazard  = second_found && dpm_is_hazard(req[first_idx], req[second_idx]);
      grant_a = first_found && !i_reset;
      grant_b = grant_a && second_found && !hazard;

      ready = '0;
      if (grant_a) ready[first_idx]  = 1'b1;
      if (grant_b) ready[second_idx] = 1'b1;

      last_idx = grant_b ? second_idx : first_idx;
      next_ptr = (int'(last_idx) == N - 1) ? '0 : last_idx + 1'b1;

      for (int i = 0; i < N; i++) begin
         lane_port[i] = (grant_b && second_idx == PTR_W'(i)) ? PORT_B : PORT_A;
      end
   end

   always_comb begin
      o_mem_addr_a  = '0;
      o_mem_wdata_a = '0;
      o_mem_bmask_a = '0;
      o_mem_wren_a  = 1'b0;
      o_mem_addr_b  = '0;
      o_mem_wdata_b = '0;
      o_mem_bmask_b = '0;
      o_mem_wren_b  = 1'b0;
      if (grant_a) begin
         o_mem_addr_a  = ADDR_W'(req[first_idx].addr);
         o_mem_wdata_a = req[first_idx].wdata;
         o_mem_bmask_a = req[first_idx].bmask;
         o_mem_wren_a  = req[first_idx].we;
      end
      if (grant_b) begin
         o_mem_addr_b  = ADDR_W'(req[second_idx].addr);
         o_mem_wdata_b = req[second_idx].wdata;
         o_mem_bmask_b = req[second_idx].bmask;
         o_mem_wren_b  = req[second_idx].we;
      end
   end

   // Read data is captured in the grant cycle, so it reflects pre-write contents.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         rr_ptr      <= '0;
         rsp_valid_q <= '0;
         rsp_rdata_q <= '0;
      end else begin
         if (grant_a) rr_ptr <= next_ptr;
         rsp_valid_q <= ready;
         for (int i = 0; i < N; i++) begin
            if (ready[i]) begin
               if (req[i].we)                   rsp_rdata_q[i] <= '0;
               else if (lane_port[i] == PORT_A) rsp_rdata_q[i] <= i_mem_rdata_a;
               else                             rsp_rdata_q[i] <= i_mem_rdata_b;
            end
         end
      end
   end

   assign req_if.req_ready = ready;
   assign req_if.rsp_valid = rsp_valid_q;
   assign req_if.rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_dpm_port_arbiter.sv
// Directed bench for dpm_port_arbiter with a byte-masked 64K x 32 memory model.
module tb_dpm_port_arbiter;
   import dpm_arb_pkg::*;

   localparam int N = 4;

   logic        i_clk = 1'b0;
   logic        i_reset = 1'b1;
   logic [15:0] mem_addr_a, mem_addr_b;
   logic [31:0] mem_wdata_a, mem_wdata_b, mem_rdata_a, mem_rdata_b;
   logic [3:0]  mem_bmask_a, mem_bmask_b;
   logic        mem_wren_a, mem_wren_b;

   logic        pre_en = 1'b0;
   logic [15:0] pre_addr = '0;
   logic [31:0] pre_data = '0;
   logic [31:0] mem [0:65535];

   int checks = 0;
   int errors = 0;

   dpm_port_arbiter_if #(.N(N), .ADDR_W(16)) bus ();

   dpm_port_arbiter #(.N(N), .ADDR_W(16)) dut (
      .i_clk         (i_clk),
      .i_reset       (i_reset),
      .req_if        (bus),
      .o_mem_addr_a  (mem_addr_a),
      .o_mem_addr_b  (mem_addr_b),
      .o_mem_wdata_a (mem_wdata_a),
      .o_mem_wdata_b (mem_wdata_b),
      .o_mem_bmask_a (mem_bmask_a),
      .o_mem_bmask_b (mem_bmask_b),
      .o_mem_wren_a  (mem_wren_a),
      .o_mem_wren_b  (mem_wren_b),
      .i_mem_rdata_a (mem_rdata_a),
      .i_mem_rdata_b (mem_rdata_b)
   );

   always #5 i_clk = ~i_clk;

   function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                         input logic [3:0] mask);
      logic [31:0] r;
      r = old_w;
      for (int b = 0; b < 4; b++) if (mask[b]) r[b*8 +: 8] = new_w[b*8 +: 8];
      return r;
   endfunction

   assign mem_rdata_a = mem[mem_addr_a];
   assign mem_rdata_b = mem[mem_addr_b];

   always @(posedge i_clk) begin
      if (pre_en) mem[pre_addr] <= pre_data;
      if (mem_wren_a) mem[mem_addr_a] <= merge(mem[mem_addr_a], mem_wdata_a, mem_bmask_a);
      if (mem_wren_b) mem[mem_addr_b] <= merge(mem[mem_addr_b], mem_wdata_b, mem_bmask_b);
   end

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic preload(input logic [15:0] a, input logic [31:0] d);
      pre_en = 1'b1; pre_addr = a; pre_data = d;
      tick();
      pre_en = 1'b0;
   endtask

   task automatic idle_all();
      bus.req_valid = '0; bus.req_we = '0; bus.req_addr = '0;
      bus.req_wdata = '0; bus.req_bmask = '0;
   endtask

   task automatic set_req(input int i, input logic we, input logic [15:0] a,
                          input logic [31:0] d, input logic [3:0] m);
      bus.req_valid[i] = 1'b1; bus.req_we[i] = we; bus.req_addr[i] = a;
      bus.req_wdata[i] = d; bus.req_bmask[i] = m;
   endtask

   task automatic do_reset();
      idle_all();
      i_reset = 1'b1;
      tick(); tick();
      i_reset = 1'b0;
   endtask

   task automatic test_reset();
      idle_all();
      for (int i = 0; i < N; i++) preload(16'h0100 + 16'(i*4), 32'hA000_0000 + 32'(i));
      i_reset = 1'b1;
      for (int i = 0; i < N; i++) set_req(i, 1'b0, 16'h0100 + 16'(i*4), '0, '0);
      @(negedge i_clk);
      checks++;
      if (bus.req_ready !== 4'b0000 || mem_wren_a !== 1'b0 || mem_wren_b !== 1'b0 || mem_addr_a !== 16'h0) begin
         errors++;
         $display("[TB] FAIL reset_outputs ready=%b wren=%b%b addr_a=%h required ready=0000 wren=00 addr_a=0000",
                  bus.req_ready, mem_wren_a, mem_wren_b, mem_addr_a);
      end
      tick();
      @(negedge i_clk);
      checks++;
      if (bus.req_ready !== 4'b0000 || bus.rsp_valid !== 4'b0000) begin
         errors++;
         $display("[TB] FAIL reset_hold ready=%b rsp_valid=%b required 0000/0000", bus.req_ready, bus.rsp_valid);
      end
      tick();
      i_reset = 1'b0;
      @(negedge i_clk);
      checks++;
      if (bus.req_ready !== 4'b0011 || mem_addr_a !== 16'h0100 || mem_addr_b !== 16'h0104) begin
         errors++;
         $display("[TB] FAIL reset_first_grant ready=%b addr_a=%h addr_b=%h required 0011/0100/0104",
                  bus.req_ready, mem_addr_a, mem_addr_b);
      end
      tick();
      checks++;
      if (bus.rsp_valid !== 4'b0011 || bus.rsp_rdata[0] !== 32'hA000_0000 ||
          bus.rsp_rdata[1] !== 32'hA000_0001 || bus.rsp_rdata[2] !== 32'h0) begin
         errors++;
         $display("[TB] FAIL reset_first_rsp rsp_valid=%b rd0=%h rd1=%h rd2=%h required 0011/a0000000/a0000001/0",
                  bus.rsp_valid, bus.rsp_rdata[0], bus.rsp_rdata[1], bus.rsp_rdata[2]);
      end
      idle_all();
   endtask

   task automatic test_round_robin();
      logic [3:0] exp_grant [3];
      exp_grant[0] = 4'b0011; exp_grant[1] = 4'b1100; exp_grant[2] = 4'b0011;
      do_reset();
      for (int i = 0; i < N; i++) set_req(i, 1'b0, 16'h0100 + 16'(i*4), '0, '0);
      for (int c = 0; c < 3; c++) begin
         @(negedge i_clk);
         checks++;
         if (bus.req_ready !== exp_grant[c]) begin
            errors++;
            $display("[TB] FAIL rr_grant_%0d ready=%b required %b", c, bus.req_ready, exp_grant[c]);
         end
         tick();
         checks++;
         if (bus.rsp_valid !== exp_grant[c]) begin
            errors++;
            $display("[TB] FAIL rr_rsp_%0d rsp_valid=%b required %b", c, bus.rsp_valid, exp_grant[c]);
         end
      end
      checks++;
      if (bus.rsp_rdata[2] !== 32'hA000_0002 || bus.rsp_rdata[3] !== 32'hA000_0003) begin
         errors++;
         $display("[TB] FAIL rr_rdata rd2=%h rd3=%h required a0000002/a0000003", bus.rsp_rdata[2], bus.rsp_rdata[3]);
      end
      idle_all();
      tick();
      checks++;
      if (bus.rsp_valid !== 4'b0000) begin
         errors++;
         $display("[TB] FAIL rr_rsp_drop rsp_valid=%b required 0000", bus.rsp_valid);
      end
   endtask

   task automatic test_write_read();
      do_reset();
      preload(16'h0010, 32'h1122_3344);
      set_req(0, 1'b1, 16'h0010, 32'hDEAD_BEEF, 4'b0101);
      @(negedge i_clk);
      checks++;
      if (bus.req_ready !== 4'b0001 || mem_wren_a !== 1'b1 || mem_bmask_a !== 4'b0101 ||
          mem_wdata_a !== 32'hDEAD_BEEF || mem_wren_b !== 1'b0 || mem_bmask_b !== 4'b0000) begin
         errors++;
         $display("[TB] FAIL wr_drive ready=%b wren_a=%b bmask_a=%b wdata_a=%h wren_b=%b bmask_b=%b required 0001/1/0101/deadbeef/0/0000",
                  bus.req_ready, mem_wren_a, mem_bmask_a, mem_wdata_a, mem_wren_b, mem_bmask_b);
      end
      tick();
      checks++;
      if (bus.rsp_valid !== 4'b0001 || bus.rsp_rdata[0] !== 32'h0) begin
         errors++;
         $display("[TB] FAIL wr_ack rsp_valid=%b rd0=%h required 0001/00000000", bus.rsp_valid, bus.rsp_rdata[0]);
      end
      idle_all();
      set_req(1, 1'b0, 16'h0010, '0, '0);
      @(negedge i_clk);
      checks++;
      if (bus.req_ready !== 4'b0010 || mem_addr_a !== 16'h0010) begin
         errors++;
         $display("[TB] FAIL rd_grant ready=%b addr_a=%h required 0010/0010", bus.req_ready, mem_addr_a);
      end
      tick();
      checks++;
      if (bus.rsp_valid !== 4'b0010 || bus.rsp_rdata[1] !== 32'h11AD_33EF) begin
         errors++;
         $display("[TB] FAIL rd_after_wr rsp_valid=%b rd1=%h required 0010/11ad33ef", bus.rsp_valid, bus.rsp_rdata[1]);
      end
      idle_all();
   endtask

   task automatic test_hazard();
      do_reset();
      preload(16'h0020, 32'hAAAA_AAAA);
      set_req(0, 1'b1, 16'h0020, 32'h1234_5678, 4'b1111);
      set_req(1, 1'b0, 16'h0020, '0, '0);
      @(negedge i_clk);
      checks++;
      if (bus.req_ready !== 4'b0001 || mem_wren_b !== 1'b0 || mem_addr_b !== 16'h0) begin
         errors++;
         $display("[TB] FAIL hazard_block ready=%b wren_b=%b addr_b=%h required 0001/0/0000",
                  bus.req_ready, mem_wren_b, mem_addr_b);
      end
      tick();
      bus.req_valid[0] = 1'b0;
      @(negedge i_clk);
      checks++;
      if (bus.req_ready !== 4'b0010 || mem_addr_a !== 16'h0020) begin
         errors++;
         $display("[TB] FAIL hazard_retry ready=%b addr_a=%h required 0010/0020", bus.req_ready, mem_addr_a);
      end
      tick();
      checks++;
      if (bus.rsp_valid !== 4'b0010 || bus.rsp_rdata[1] !== 32'h1234_5678) begin
         errors++;
         $display("[TB] FAIL hazard_new_data rsp_valid=%b rd1=%h required 0010/12345678", bus.rsp_valid, bus.rsp_rdata[1]);
      end
      set_req(0, 1'b0, 16'h0020, '0, '0);
      @(negedge i_clk);
      checks++;
      if (bus.req_ready !== 4'b0011 || mem_addr_b !== 16'h0020) begin
         errors++;
         $display("[TB] FAIL dual_read ready=%b addr_b=%h required 0011/0020", bus.req_ready, mem_addr_b);
      end
      tick();
      checks++;
      if (bus.rsp_rdata[0] !== 32'h1234_5678 || bus.rsp_rdata[1] !== 32'h1234_5678) begin
         errors++;
         $display("[TB] FAIL dual_read_data rd0=%h rd1=%h required 12345678/12345678", bus.rsp_rdata[0], bus.rsp_rdata[1]);
      end
      idle_all();
   endtask

   task automatic test_starvation();
      logic [3:0] exp;
      do_reset();
      set_req(0, 1'b1, 16'h0030, 32'h0000_0A0A, 4'b1111);
      set_req(2, 1'b1, 16'h0030, 32'h0000_0C0C, 4'b1111);
      for (int c = 0; c < 6; c++) begin
         exp = (c % 2 == 0) ? 4'b0001 : 4'b0100;
         @(negedge i_clk);
         checks++;
         if (bus.req_ready !== exp || mem_wren_b !== 1'b0) begin
            errors++;
            $display("[TB] FAIL starve_%0d ready=%b wren_b=%b required %b/0", c, bus.req_ready, mem_wren_b, exp);
         end
         tick();
      end
      idle_all();
   endtask

   task automatic test_reset_mid();
      do_reset();
      preload(16'h0040, 32'h5555_0040);
      set_req(1, 1'b0, 16'h0040, '0, '0);
      @(negedge i_clk);
      checks++;
      if (bus.req_ready !== 4'b0010) begin
         errors++;
         $display("[TB] FAIL mid_pre_grant ready=%b required 0010", bus.req_ready);
      end
      tick();
      idle_all();
      set_req(3, 1'b0, 16'h0040, '0, '0);
      @(negedge i_clk);
      checks++;
      if (bus.req_ready !== 4'b1000) begin
         errors++;
         $display("[TB] FAIL mid_grant3 ready=%b required 1000", bus.req_ready);
      end
      #3;
      i_reset = 1'b1;
      tick();
      checks++;
      if (bus.rsp_valid !== 4'b0000) begin
         errors++;
         $display("[TB] FAIL mid_rsp_dropped rsp_valid=%b required 0000", bus.rsp_valid);
      end
      tick();
      i_reset = 1'b0;
      for (int i = 0; i < N; i++) set_req(i, 1'b0, 16'h0040, '0, '0);
      @(negedge i_clk);
      checks++;
      if (bus.req_ready !== 4'b0011) begin
         errors++;
         $display("[TB] FAIL mid_ptr_cleared ready=%b required 0011", bus.req_ready);
      end
      tick();
      idle_all();
   endtask

   initial begin
      idle_all();
      test_reset();
      test_round_robin();
      test_write_read();
      test_hazard();
      test_starvation();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
